morse_char_decoder: RTL and testbench



---
 rtl/morse_char_decoder.sv | 210 +++++++++++++++++++++
 tb/tb_morse_char_decoder.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_char_decoder.sv
// morse_char_decoder
//   Walks a snapshot of the stored Morse sequences from oldest (highest slot)
//   to newest (slot 0). Each non-empty sequence is decoded to ASCII and
//   offered downstream over a valid/ready handshake. Empty slots are skipped.
//   Undecodable sequences produce UNKNOWN_CHAR and raise a sticky error flag.
//
// Ports
//   clk         system clock
//   reset       synchronous reset, active-high
//   start       one-cycle request to decode the current seqs_in (IDLE only)
//   seqs_in     NUM_SLOTS packed sequences, slot k = seqs_in[SEQ_W*k +: SEQ_W]
//   char_out    decoded ASCII character
//   char_valid  char_out valid, held until accepted
//   char_ready  downstream accept
//   busy        walk in progress
//   done        one-cycle pulse when the walk completes
//   char_count  characters emitted in the current/last walk
//   error       sticky invalid/unmapped flag since the last start
module morse_char_decoder #(
  parameter int          NUM_SLOTS    = 16,
  parameter int          SEQ_W        = 10,
  parameter logic [7:0]  UNKNOWN_CHAR = 8'h3F
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [NUM_SLOTS*SEQ_W-1:0]         seqs_in,
  output logic [7:0]                         char_out,
  output logic                               char_valid,
  input  logic                               char_ready,
  output logic                               busy,
  output logic                               done,
  output logic [$clog2(NUM_SLOTS+1)-1:0]     char_count,
  output logic                               error
);

  localparam int IDX_W   = $clog2(NUM_SLOTS);
  localparam int CNT_W   = $clog2(NUM_SLOTS+1);
  localparam int NUM_SYM = SEQ_W / 2;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_EMIT, S_DONE} state_t;

  state_t                     state_q;
  state_t                     state_d;
  logic [NUM_SLOTS*SEQ_W-1:0] snap_q;
  logic [IDX_W-1:0]           idx_q;
  logic [SEQ_W-1:0]           cur_seq;
  logic                       cur_empty;
  logic                       last_slot;
  logic                       accept;
  logic [7:0]                 dec_char;
  logic                       dec_err;

  // Returns {err, char}. Symbols are packed into pat with the first symbol
  // ending up as the most significant of the len used bits (dot=0, dash=1),
  // so {len, pat} uniquely identifies a Morse pattern.
  function automatic logic [8:0] decode_seq(input logic [SEQ_W-1:0] seq);
    logic [2:0] len;
    logic [4:0] pat;
    logic       bad;
    logic       stop;
    logic       hit;
    logic [1:0] sym;
    logic [7:0] ch;
    len  = '0;
    pat  = '0;
    bad  = 1'b0;
    stop = 1'b0;
    for (int i = 0; i < NUM_SYM; i++) begin
      sym = seq[SEQ_W-1-2*i -: 2];
      if (!stop) begin
        if (sym == 2'b11) begin
          stop = 1'b1;
        end else if (sym == 2'b10) begin
          bad  = 1'b1;
          stop = 1'b1;
        end else begin
          pat = {pat[3:0], sym[0]};
          len = len + 3'd1;
        end
      end
    end
    hit = 1'b1;
    ch  = UNKNOWN_CHAR;
    case ({len, pat})
      8'b001_00000: ch = 8'h45; // E
      8'b001_00001: ch = 8'h54; // T
      8'b010_00001: ch = 8'h41; // A
      8'b010_00000: ch = 8'h49; // I
      8'b010_00011: ch = 8'h4D; // M
      8'b010_00010: ch = 8'h4E; // N
      8'b011_00000: ch = 8'h53; // S
      8'b011_00001: ch = 8'h55; // U
      8'b011_00010: ch = 8'h52; // R
      8'b011_00011: ch = 8'h57; // W
      8'b011_00100: ch = 8'h44; // D
      8'b011_00101: ch = 8'h4B; // K
      8'b011_00110: ch = 8'h47; // G
      8'b011_00111: ch = 8'h4F; // O
      8'b100_00000: ch = 8'h48; // H
      8'b100_00001: ch = 8'h56; // V
      8'b100_00010: ch = 8'h46; // F
      8'b100_00100: ch = 8'h4C; // L
      8'b100_00110: ch = 8'h50; // P
      8'b100_00111: ch = 8'h4A; // J
      8'b100_01000: ch = 8'h42; // B
      8'b100_01001: ch = 8'h58; // X
      8'b100_01010: ch = 8'h43; // C
      8'b100_01011: ch = 8'h59; // Y
      8'b100_01100: ch = 8'h5A; // Z
      8'b100_01101: ch = 8'h51; // Q
      8'b101_00000: ch = 8'h35; // 5
      8'b101_00001: ch = 8'h34; // 4
      8'b101_00011: ch = 8'h33; // 3
      8'b101_00111: ch = 8'h32; // 2
      8'b101_01111: ch = 8'h31; // 1
      8'b101_10000: ch = 8'h36; // 6
      8'b101_11000: ch = 8'h37; // 7
      8'b101_11100: ch = 8'h38; // 8
      8'b101_11110: ch = 8'h39; // 9
      8'b101_11111: ch = 8'h30; // 0
      default:      hit = 1'b0;
    endcase
    if (bad || !hit) begin
      return {1'b1, UNKNOWN_CHAR};
    end
    return {1'b0, ch};
  endfunction

  always_comb begin
    cur_seq   = snap_q[idx_q*SEQ_W +: SEQ_W];
    cur_empty = (cur_seq[SEQ_W-1 -: 2] == 2'b11);
    last_slot = (idx_q == '0);
    accept    = char_valid && char_ready;
    {dec_err, dec_char} = decode_seq(cur_seq);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_SCAN;
      S_SCAN: begin
        if (!cur_empty)     state_d = S_EMIT;
        else if (last_slot) state_d = S_DONE;
      end
      S_EMIT: begin
        if (accept) state_d = last_slot ? S_DONE : S_SCAN;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q == S_SCAN) || (state_q == S_EMIT);
    done = (state_q == S_DONE);
  end

  // Walk datapath: snapshot, slot index, emitted character and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_q     <= '1;
      idx_q      <= '0;
      char_out   <= '0;
      char_valid <= 1'b0;
      char_count <= '0;
      error      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            snap_q     <= seqs_in;
            idx_q      <= IDX_W'(NUM_SLOTS-1);
            char_count <= '0;
            error      <= 1'b0;
          end
        end
        S_SCAN: begin
          if (cur_empty) begin
            if (!last_slot) idx_q <= idx_q - IDX_W'(1);
          end else begin
            char_out   <= dec_char;
            char_valid <= 1'b1;
            if (dec_err) error <= 1'b1;
          end
        end
        S_EMIT: begin
          if (accept) begin
            char_valid <= 1'b0;
            char_count <= char_count + CNT_W'(1);
            if (!last_slot) idx_q <= idx_q - IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_char_decoder.sv
module tb_morse_char_decoder;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [159:0] seqs_in = '1;
  logic [7:0]   char_out;
  logic         char_valid;
  logic         char_ready = 1'b1;
  logic         busy;
  logic         done;
  logic [4:0]   char_count;
  logic         error;

  morse_char_decoder dut (
    .clk(clk), .reset(reset), .start(start), .seqs_in(seqs_in),
    .char_out(char_out), .char_valid(char_valid), .char_ready(char_ready),
    .busy(busy), .done(done), .char_count(char_count), .error(error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ITU Morse table: entries 0..25 are A..Z, 26..35 are 0..9
  string mtab[36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                      ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                      "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
                      "-----", ".----", "..---", "...--", "....-", ".....", "-....",
                      "--...", "---..", "----."};

  function automatic logic [7:0] tab_char(input int k);
    return (k < 26) ? 8'(8'h41 + k) : 8'(8'h30 + k - 26);
  endfunction

  function automatic void model_decode(input logic [9:0] s, output logic [7:0] c, output bit e);
    string m;
    bit bad;
    logic [1:0] p;
    m = "";
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      p = s[9-2*i -: 2];
      if (p == 2'b11) break;
      if (p == 2'b10) begin bad = 1'b1; break; end
      if (p == 2'b01) m = {m, "-"}; else m = {m, "."};
    end
    c = 8'h3F;
    e = 1'b1;
    if (!bad) begin
      for (int k = 0; k < 36; k++) begin
        if (mtab[k] == m) begin c = tab_char(k); e = 1'b0; end
      end
    end
  endfunction

  function automatic logic [9:0] encode(input string m);
    logic [9:0] v;
    int len;
    len = m.len();
    v = '0;
    for (int i = 0; i < 5; i++) begin
      if (i < len)       v[9-2*i -: 2] = (m[i] == "-") ? 2'b01 : 2'b00;
      else if (i == len) v[9-2*i -: 2] = 2'b11;
      else               v[9-2*i -: 2] = 2'($urandom_range(0, 3));
    end
    return v;
  endfunction

  // Reference model state, owned by the compare process
  typedef struct { logic [7:0] c; bit e; } exp_t;
  exp_t       exp_q[$];
  exp_t       cur_x;
  logic [7:0] acc_log[$];
  bit         active = 1'b0;
  bit         err_sofar = 1'b0;
  bit         last_err = 1'b0;
  bit         prev_reset = 1'b0;
  bit         prev_stall = 1'b0;
  bit         first_seen = 1'b0;
  logic [7:0] prev_out = '0;
  logic [9:0] sl;
  int         s_cyc = 0, n_ne = 0, n_lead = 0, stalls = 0, acc = 0, last_count = 0;
  int         done_cyc = 0, last_start = 0, walks_done = 0;
  logic [7:0] mc;
  bit         me;

  always @(negedge clk) begin
    if (prev_reset && !reset) begin
      chk("rst_char_out", char_out, 0);
      chk("rst_char_valid", char_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_char_count", char_count, 0);
      chk("rst_error", error, 0);
    end
    if (reset) begin
      active = 1'b0;
      exp_q.delete();
      last_count = 0;
      last_err = 1'b0;
      prev_stall = 1'b0;
    end else if (!active) begin
      chk("idle_valid", char_valid, 0);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_count_hold", char_count, last_count);
      chk("idle_error_hold", error, last_err);
      if (start) begin
        exp_q.delete();
        acc_log.delete();
        n_ne = 0; n_lead = 0;
        for (int k = 15; k >= 0; k--) begin
          sl = seqs_in[10*k +: 10];
          if (sl[9:8] != 2'b11) begin
            model_decode(sl, mc, me);
            cur_x.c = mc; cur_x.e = me;
            exp_q.push_back(cur_x);
            n_ne++;
          end else if (n_ne == 0) begin
            n_lead++;
          end
        end
        active = 1'b1; s_cyc = cyc; acc = 0; err_sofar = 1'b0;
        stalls = 0; first_seen = 1'b0; prev_stall = 1'b0;
      end
    end else if (cyc > s_cyc) begin
      chk("walk_count", char_count, acc);
      if (done) begin
        chk("done_cycle", cyc - s_cyc, 17 + n_ne + stalls);
        chk("done_busy", busy, 0);
        chk("done_valid", char_valid, 0);
        chk("done_pending", exp_q.size(), 0);
        chk("done_error", error, err_sofar);
        last_count = acc; last_err = err_sofar;
        done_cyc = cyc; last_start = s_cyc;
        active = 1'b0;
        walks_done++;
      end else begin
        chk("walk_busy", busy, 1);
        if (char_valid && exp_q.size() > 0) chk("walk_error", error, err_sofar | exp_q[0].e);
        else chk("walk_error", error, err_sofar);
        if (prev_stall) begin
          chk("hold_valid", char_valid, 1);
          chk("hold_char", char_out, prev_out);
        end
        if (char_valid) begin
          if (!first_seen) begin
            chk("first_latency", cyc - s_cyc, 2 + n_lead);
            first_seen = 1'b1;
          end
          if (exp_q.size() == 0) begin
            chk("extra_char", char_valid, 0);
          end else if (char_ready) begin
            cur_x = exp_q.pop_front();
            chk("char", char_out, cur_x.c);
            err_sofar = err_sofar | cur_x.e;
            acc++;
            acc_log.push_back(char_out);
            prev_stall = 1'b0;
          end else begin
            stalls++;
            prev_stall = 1'b1;
            prev_out = char_out;
          end
        end else begin
          prev_stall = 1'b0;
        end
        if (cyc > s_cyc + 17 + n_ne + stalls) begin
          chk("done_timeout", done, 1);
          active = 1'b0;
        end
      end
    end
    prev_reset = reset;
  end

  // Ready driver: 0 = always ready, 1 = random, 2 = stall 2nd char 5 cycles, 3 = never ready
  int rmode = 0;
  int hold = 0;
  always @(posedge clk) begin
    #1;
    if (!busy && !char_valid) hold = 0;
    case (rmode)
      0: char_ready = 1'b1;
      1: char_ready = 1'($urandom_range(0, 1));
      2: begin
        if (char_valid && acc == 1 && hold < 5) begin
          char_ready = 1'b0;
          hold++;
        end else begin
          char_ready = 1'b1;
        end
      end
      default: char_ready = 1'b0;
    endcase
  end

  logic [9:0] slots[16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_slots();
    for (int k = 0; k < 16; k++) slots[k] = 10'h3FF;
  endtask

  task automatic launch();
    for (int k = 0; k < 16; k++) seqs_in[10*k +: 10] = slots[k];
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    int w0;
    w0 = walks_done;
    for (int i = 0; i < 400 && walks_done == w0; i++) tick();
    if (walks_done == w0) chk("walk_finished", walks_done, w0 + 1);
    tick();
  endtask

  task automatic chk_log(input string name, input int n, input logic [7:0] e0,
                         input logic [7:0] e1, input logic [7:0] e2);
    logic [7:0] ev[3];
    ev[0] = e0; ev[1] = e1; ev[2] = e2;
    chk({name, "_len"}, acc_log.size(), n);
    for (int i = 0; i < n && i < acc_log.size(); i++) chk(name, acc_log[i], ev[i]);
  endtask

  task automatic pin(input logic [9:0] s, input logic [7:0] c, input bit e);
    logic [7:0] gc;
    bit ge;
    model_decode(s, gc, ge);
    chk("model_char", gc, c);
    chk("model_err", 32'(ge), 32'(e));
  endtask

  task automatic load_sos();
    clear_slots();
    slots[2] = 10'h00F;
    slots[1] = 10'h15F;
    slots[0] = 10'h00F;
  endtask

  logic [9:0] r;
  int n;

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    tick();

    pin(10'h00F, 8'h53, 0);
    pin(10'h15F, 8'h4F, 0);
    pin(10'h155, 8'h30, 0);
    pin(10'h000, 8'h35, 0);
    pin(10'h07F, 8'h41, 0);
    pin(10'h0EA, 8'h45, 0);
    pin(10'h05F, 8'h57, 0);
    pin(10'h2FF, 8'h3F, 1);
    pin(10'h017, 8'h3F, 1);

    // SOS, always ready
    load_sos();
    launch();
    wait_done();
    chk_log("sos", 3, 8'h53, 8'h4F, 8'h53);
    chk("sos_count", char_count, 3);
    chk("sos_error", error, 0);

    // Backpressure on the second character
    rmode = 2;
    launch();
    wait_done();
    chk_log("bp", 3, 8'h53, 8'h4F, 8'h53);
    chk("bp_stalls", stalls, 5);
    chk("bp_count", char_count, 3);
    rmode = 0;

    // All slots empty
    clear_slots();
    launch();
    wait_done();
    chk("empty_chars", acc_log.size(), 0);
    chk("empty_done_cycles", done_cyc - last_start, 17);
    chk("empty_count", char_count, 0);

    // Digits
    clear_slots();
    slots[0] = 10'h155;
    slots[1] = 10'h000;
    launch();
    wait_done();
    chk_log("digits", 2, 8'h35, 8'h30, 8'h00);

    // Full load
    for (int k = 0; k < 16; k++) slots[k] = encode(mtab[$urandom_range(0, 35)]);
    launch();
    wait_done();
    chk("full_count", char_count, 16);
    chk("full_chars", acc_log.size(), 16);

    // Invalid and unmapped sequences; error sticky then cleared by next start
    clear_slots();
    slots[0] = 10'h2FF;
    slots[1] = 10'h017;
    launch();
    wait_done();
    chk_log("invalid", 2, 8'h3F, 8'h3F, 8'h00);
    chk("invalid_error", error, 1);
    tick();
    chk("invalid_error_sticky", error, 1);
    load_sos();
    launch();
    chk("error_cleared", error, 0);
    wait_done();
    chk("sos2_error", error, 0);

    // Start ignored during EMIT, then reset mid-walk
    rmode = 3;
    launch();
    for (int i = 0; i < 20 && !char_valid; i++) tick();
    chk("emit_reached", char_valid, 1);
    seqs_in = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("ign_valid", char_valid, 1);
    chk("ign_char", char_out, 8'h53);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_valid", char_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_count", char_count, 0);
    chk("midrst_error", error, 0);
    rmode = 0;
    load_sos();
    launch();
    wait_done();
    chk_log("after_rst", 3, 8'h53, 8'h4F, 8'h53);

    // Randomized walks with random backpressure and snapshot disturbance
    rmode = 1;
    for (int t = 0; t < 40; t++) begin
      n = $urandom_range(0, 16);
      for (int k = 0; k < 16; k++) begin
        if (k < n) begin
          if ($urandom_range(0, 4) == 0) begin
            r = 10'($urandom);
            if (r[9:8] == 2'b11) r[9:8] = 2'b10;
            slots[k] = r;
          end else begin
            slots[k] = encode(mtab[$urandom_range(0, 35)]);
          end
        end else begin
          slots[k] = 10'h3FF;
        end
      end
      launch();
      if ($urandom_range(0, 1) == 1) begin
        tick();
        seqs_in = {$urandom, $urandom, $urandom, $urandom, $urandom};
      end
      wait_done();
      chk("rand_count", char_count, n);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
